// File: rtl/half_adder.sv
// Registered multi-lane half adder with carry summary flags.
// Ports:
//   clk       - rising-edge clock for all state
//   rst_n     - synchronous active-low reset
//   a, b      - per-lane addend bits, WIDTH lanes
//   in_valid  - a/b qualify this cycle
//   sum       - registered a ^ b per lane
//   carry     - registered a & b per lane
//   out_valid - pulses the cycle after each accepted operation
//   carry_any - registered OR of the captured carry vector
//   carry_pop - registered number of set bits in the captured carry
//   op_count  - saturating count of accepted operations since reset
module half_adder #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [WIDTH-1:0]             a,
  input  logic [WIDTH-1:0]             b,
  input  logic                         in_valid,
  output logic [WIDTH-1:0]             sum,
  output logic [WIDTH-1:0]             carry,
  output logic                         out_valid,
  output logic                         carry_any,
  output logic [$clog2(WIDTH+1)-1:0]   carry_pop,
  output logic [CNT_W-1:0]             op_count
);

  localparam int PW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] carry_q, carry_d;
  logic             vld_q, vld_d;
  logic             any_q, any_d;
  logic [PW-1:0]    pop_q, pop_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  function automatic logic [PW-1:0] popcnt(
    input logic [WIDTH-1:0] v
  );
    logic [PW-1:0] n;
    n = '0;
    for (int i = 0; i < WIDTH; i++) begin
      n = n + PW'(v[i]);
    end
    return n;
  endfunction

  // Summary flags derive from the same sample as
  // carry, so they stay coherent with it.
  always_comb begin
    sum_d   = sum_q;
    carry_d = carry_q;
    any_d   = any_q;
    pop_d   = pop_q;
    cnt_d   = cnt_q;
    vld_d   = in_valid;
    if (in_valid) begin
      sum_d   = a ^ b;
      carry_d = a & b;
      any_d   = |(a & b);
      pop_d   = popcnt(a & b);
      if (cnt_q != '1) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q   <= '0;
      carry_q <= '0;
      vld_q   <= 1'b0;
      any_q   <= 1'b0;
      pop_q   <= '0;
      cnt_q   <= '0;
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
      vld_q   <= vld_d;
      any_q   <= any_d;
      pop_q   <= pop_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sum       = sum_q;
  assign carry     = carry_q;
  assign out_valid = vld_q;
  assign carry_any = any_q;
  assign carry_pop = pop_q;
  assign op_count  = cnt_q;

endmodule

// File: tb/tb_half_adder.sv
// Bench for half_adder: three widths share one stimulus,
// checked against a lane-arithmetic model plus literals.
module tb_half_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       vin = 1'b0;

  logic        s1, c1, v1, y1;
  logic [0:0]  p1;
  logic [15:0] n1;
  logic [3:0]  s4, c4;
  logic        v4, y4;
  logic [2:0]  p4;
  logic [15:0] n4;
  logic [7:0]  s8, c8;
  logic        v8, y8;
  logic [3:0]  p8;
  logic [3:0]  n8;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  half_adder #(.WIDTH(1), .CNT_W(16)) u1 (
    .clk(clk), .rst_n(rst_n),
    .a(a8[0]), .b(b8[0]), .in_valid(vin),
    .sum(s1), .carry(c1), .out_valid(v1),
    .carry_any(y1), .carry_pop(p1), .op_count(n1)
  );

  half_adder #(.WIDTH(4), .CNT_W(16)) u4 (
    .clk(clk), .rst_n(rst_n),
    .a(a8[3:0]), .b(b8[3:0]), .in_valid(vin),
    .sum(s4), .carry(c4), .out_valid(v4),
    .carry_any(y4), .carry_pop(p4), .op_count(n4)
  );

  half_adder #(.WIDTH(8), .CNT_W(4)) u8 (
    .clk(clk), .rst_n(rst_n),
    .a(a8), .b(b8), .in_valid(vin),
    .sum(s8), .carry(c8), .out_valid(v8),
    .carry_any(y8), .carry_pop(p8), .op_count(n8)
  );

  task automatic chk(input string n,
                     input longint got,
                     input longint exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s got=%0h exp=%0h", n, got, exp);
  endtask

  // Model: each lane is the integer a+b; carry is
  // the twos digit, sum the ones digit.
  int   W[3]    = '{1, 4, 8};
  int   MAXC[3] = '{65535, 65535, 15};
  logic [7:0] m_sum[3];
  logic [7:0] m_car[3];
  int   m_pop[3];
  bit   m_any[3];
  int   m_cnt[3];
  bit   m_vld;
  bit   started = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      started <= 1'b1;
      m_vld   <= 1'b0;
      for (int k = 0; k < 3; k++) begin
        m_sum[k] <= '0;
        m_car[k] <= '0;
        m_pop[k] <= 0;
        m_any[k] <= 1'b0;
        m_cnt[k] <= 0;
      end
    end else begin
      m_vld <= vin;
      if (vin) begin
        for (int k = 0; k < 3; k++) begin
          logic [7:0] s, c;
          int np;
          s  = '0;
          c  = '0;
          np = 0;
          for (int i = 0; i < W[k]; i++) begin
            int t;
            t = int'(a8[i]) + int'(b8[i]);
            s[i] = (t % 2) == 1;
            c[i] = (t / 2) == 1;
            np += t / 2;
          end
          m_sum[k] <= s;
          m_car[k] <= c;
          m_pop[k] <= np;
          m_any[k] <= (np > 0);
          m_cnt[k] <= (m_cnt[k] + 1 > MAXC[k]) ?
                      MAXC[k] : m_cnt[k] + 1;
        end
      end
    end
  end

  task automatic cmp(input int k,
                     input logic [7:0] s,
                     input logic [7:0] c,
                     input logic v,
                     input logic y,
                     input int p,
                     input int n);
    string t;
    t = $sformatf("w%0d", W[k]);
    chk({t, "_sum"}, s, m_sum[k]);
    chk({t, "_carry"}, c, m_car[k]);
    chk({t, "_vld"}, v, m_vld);
    chk({t, "_any"}, y, m_any[k]);
    chk({t, "_pop"}, p, m_pop[k]);
    chk({t, "_cnt"}, n, m_cnt[k]);
  endtask

  always @(negedge clk) begin
    if (started) begin
      cmp(0, {7'b0, s1}, {7'b0, c1}, v1, y1,
          int'(p1), int'(n1));
      cmp(1, {4'b0, s4}, {4'b0, c4}, v4, y4,
          int'(p4), int'(n4));
      cmp(2, s8, c8, v8, y8, int'(p8), int'(n8));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic [7:0] av,
                       input logic [7:0] bv,
                       input logic v);
    a8  = av;
    b8  = bv;
    vin = v;
    tick();
  endtask

  logic [7:0] pa[4] = '{8'h0, 8'h0, 8'h1, 8'h1};
  logic [7:0] pb[4] = '{8'h0, 8'h1, 8'h0, 8'h1};
  logic       es[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  logic       ec[4] = '{1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    rst_n = 1'b0;
    drive(8'hFF, 8'hFF, 1'b1);
    drive(8'hFF, 8'hFF, 1'b1);
    chk("rst_sum", s8, 0);
    chk("rst_carry", c8, 0);
    chk("rst_vld", v8, 0);
    chk("rst_any", y8, 0);
    chk("rst_pop", p8, 0);
    chk("rst_cnt", n8, 0);

    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(pa[i], pb[i], 1'b1);
      chk($sformatf("w1_seq%0d_sum", i), s1, es[i]);
      chk($sformatf("w1_seq%0d_car", i), c1, ec[i]);
      chk($sformatf("w1_seq%0d_vld", i), v1, 1);
    end
    chk("w1_cnt4", n1, 4);

    drive(8'b0000_1100, 8'b0000_1010, 1'b1);
    chk("w4_sum", s4, 4'b0110);
    chk("w4_carry", c4, 4'b1000);
    chk("w4_any", y4, 1);
    chk("w4_pop", p4, 1);
    for (int i = 0; i < 3; i++) drive(8'hFF, 8'hFF, 1'b0);
    chk("w4_hold_sum", s4, 4'b0110);
    chk("w4_hold_carry", c4, 4'b1000);
    chk("w4_hold_vld", v4, 0);
    chk("w4_hold_cnt", n4, 5);

    drive(8'hFF, 8'hFF, 1'b1);
    chk("w8_ff_sum", s8, 8'h00);
    chk("w8_ff_carry", c8, 8'hFF);
    chk("w8_ff_pop", p8, 8);
    chk("w8_ff_any", y8, 1);

    rst_n = 1'b0;
    drive(8'hFF, 8'hFF, 1'b1);
    chk("rst2_carry", c8, 0);
    chk("rst2_cnt", n8, 0);
    chk("rst2_vld", v8, 0);
    rst_n = 1'b1;
    drive(8'h01, 8'h01, 1'b1);
    chk("post_rst_sum", s8, 0);
    chk("post_rst_carry", c8, 1);
    chk("post_rst_cnt", n8, 1);

    for (int i = 0; i < 20; i++)
      drive(8'($urandom), 8'($urandom), 1'b1);
    chk("sat_cnt", n8, 15);
    drive(8'h0, 8'h0, 1'b1);
    chk("sat_hold", n8, 15);

    for (int i = 0; i < 300; i++) begin
      rst_n = ($urandom_range(0, 29) != 0);
      drive(8'($urandom), 8'($urandom),
            1'($urandom_range(0, 3) != 0));
    end
    rst_n = 1'b1;
    drive(8'h0, 8'h0, 1'b0);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
